// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : Load/store unit between EX and WB. Accepts one EX result at a
//               time, performs an optional single-beat bus access with a
//               bounded ack wait, and returns the formatted result to WB.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    // EX side
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_res,
    input  logic [31:0] rD2,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_uns,
    input  logic [4:0]  rd_in,
    input  logic        rf_we_in,
    // Bus side
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    // WB side
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_rf_we,
    output logic        out_misalign,
    output logic        out_buserr
);

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Registered operation captured at accept
    logic [31:0] r_addr;
    logic        r_store;
    logic        r_load;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [4:0]  r_rd;
    logic        r_rf_we;
    logic        r_misalign;
    logic        r_buserr;
    logic [31:0] r_rdata;
    logic [7:0]  r_wait_cnt;

    // Bus-side registers
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_wstrb;

    // Result registers
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic [4:0]  r_out_rd;
    logic        r_out_rf_we;
    logic        r_out_misalign;
    logic        r_out_buserr;

    // Decode of the presented EX result
    logic        w_accept;
    logic        w_is_mem;
    logic        w_is_store;
    logic        w_is_load;
    logic        w_misalign;
    logic        w_go_bus;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;

    // Bus wait bookkeeping
    logic [7:0]  w_wait_inc;
    logic        w_timeout;

    // Response formatting
    logic [7:0]  w_load_byte;
    logic [15:0] w_load_half;
    logic [31:0] w_load_data;
    logic [31:0] w_resp_data;
    logic        w_resp_rf_we;

    assign w_accept   = in_valid & (r_state == IDLE);
    assign w_is_mem   = mem_re | mem_we;
    assign w_is_store = mem_we;
    assign w_is_load  = mem_re & ~mem_we;
    assign w_misalign = w_is_mem & (((mem_size == 2'b01) & alu_res[0]) |
                                    ((mem_size == 2'b10) & (alu_res[1:0] != 2'b00)) |
                                    (mem_size == 2'b11));
    assign w_go_bus   = w_is_mem & ~w_misalign;

    // An ack always wins over the timeout in the same cycle
    assign w_wait_inc = r_wait_cnt + 8'd1;
    assign w_timeout  = ~bus_ack & (w_wait_inc == c_TIMEOUT);

    // Byte lanes and write data replication for the presented access
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = rD2;
        case (mem_size)
            2'b00: begin
                w_wstrb = 4'b0001 << alu_res[1:0];
                w_wdata = {4{rD2[7:0]}};
            end
            2'b01: begin
                w_wstrb = alu_res[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{rD2[15:0]}};
            end
            2'b10: begin
                w_wstrb = 4'b1111;
                w_wdata = rD2;
            end
            default: begin
                w_wstrb = 4'b0000;
                w_wdata = rD2;
            end
        endcase
        if (!w_is_store) begin
            w_wstrb = 4'b0000;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        bus_req      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = w_go_bus ? BUS : RESP;
                end
            end
            BUS: begin
                bus_req = 1'b1;
                if (bus_ack || w_timeout) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Capture the operation and its bus image when the EX result is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= 32'd0;
            r_store     <= 1'b0;
            r_load      <= 1'b0;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_rd        <= 5'd0;
            r_rf_we     <= 1'b0;
            r_misalign  <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_bus_wstrb <= 4'b0000;
        end else if (w_accept) begin
            r_addr      <= alu_res;
            r_store     <= w_is_store;
            r_load      <= w_is_load;
            r_size      <= mem_size;
            r_uns       <= mem_uns;
            r_rd        <= rd_in;
            r_rf_we     <= rf_we_in;
            r_misalign  <= w_misalign;
            r_bus_we    <= w_is_store;
            r_bus_addr  <= {alu_res[31:2], 2'b00};
            r_bus_wdata <= w_wdata;
            r_bus_wstrb <= w_wstrb;
        end
    end

    // Wait counter, captured read data and bus error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= 8'd0;
            r_rdata    <= 32'd0;
            r_buserr   <= 1'b0;
        end else if (w_accept) begin
            r_wait_cnt <= 8'd0;
            r_buserr   <= 1'b0;
        end else if (r_state == BUS) begin
            if (bus_ack) begin
                r_rdata <= bus_rdata;
            end else begin
                r_wait_cnt <= w_wait_inc;
                if (w_timeout) begin
                    r_buserr <= 1'b1;
                end
            end
        end
    end

    // Lane selection and extension of the captured read data
    always_comb begin
        w_load_byte = r_rdata[7:0];
        case (r_addr[1:0])
            2'd0:    w_load_byte = r_rdata[7:0];
            2'd1:    w_load_byte = r_rdata[15:8];
            2'd2:    w_load_byte = r_rdata[23:16];
            default: w_load_byte = r_rdata[31:24];
        endcase
        w_load_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (r_size)
            2'b00:   w_load_data = r_uns ? {24'd0, w_load_byte}
                                         : {{24{w_load_byte[7]}}, w_load_byte};
            2'b01:   w_load_data = r_uns ? {16'd0, w_load_half}
                                         : {{16{w_load_half[15]}}, w_load_half};
            2'b10:   w_load_data = r_rdata;
            default: w_load_data = 32'd0;
        endcase
    end

    // Writeback value: ALU result for pass-through, formatted read data for
    // a successful load, zero for everything else
    always_comb begin
        w_resp_data = 32'd0;
        if (!r_load && !r_store) begin
            w_resp_data = r_addr;
        end else if (r_load && !r_misalign && !r_buserr) begin
            w_resp_data = w_load_data;
        end
        w_resp_rf_we = r_rf_we & ~r_misalign & ~r_buserr & ~r_store;
    end

    // Result register: one-cycle out_valid pulse as the RESP state completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_data     <= 32'd0;
            r_out_rd       <= 5'd0;
            r_out_rf_we    <= 1'b0;
            r_out_misalign <= 1'b0;
            r_out_buserr   <= 1'b0;
        end else if (r_state == RESP) begin
            r_out_valid    <= 1'b1;
            r_out_data     <= w_resp_data;
            r_out_rd       <= r_rd;
            r_out_rf_we    <= w_resp_rf_we;
            r_out_misalign <= r_misalign;
            r_out_buserr   <= r_buserr;
        end else begin
            r_out_valid    <= 1'b0;
            r_out_rf_we    <= 1'b0;
            r_out_misalign <= 1'b0;
            r_out_buserr   <= 1'b0;
        end
    end

    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign bus_wstrb    = r_bus_wstrb;

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_rd       = r_out_rd;
    assign out_rf_we    = r_out_rf_we;
    assign out_misalign = r_out_misalign;
    assign out_buserr   = r_out_buserr;

endmodule
`default_nettype wire
